// File: rtl/sram_sh_data_pkg.sv
// Shared types and helpers for the shared-data SRAM controller.
// SRAM_SH_DATA_CTRL_PARITY_EN adds one even-parity bit per lane to the cut.
package sram_sh_data_pkg;

    typedef enum logic {INIT, RUN} fsm_e;

    function automatic int lane_w(input int data_width, input int nb_lanes);
        return data_width / nb_lanes;
    endfunction

`ifdef SRAM_SH_DATA_CTRL_PARITY_EN
    localparam int PARITY_W = 1;
`else
    localparam int PARITY_W = 0;
`endif

endpackage

// File: rtl/GENERIC_MEM.sv
// Single-port bit-maskable memory cut: CEN/RDWEN active-low, write via BW mask, Q registered.
module GENERIC_MEM #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  CLK,
    input  logic                  CEN,
    input  logic                  RDWEN,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] D,
    input  logic [DATA_WIDTH-1:0] BW,
    output logic [DATA_WIDTH-1:0] Q
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge CLK) begin
        if (!CEN) begin
            if (!RDWEN) mem[A] <= (mem[A] & ~BW) | (D & BW);
            else        Q      <= mem[A];
        end
    end

endmodule

// File: rtl/sram_sh_data_rsp_fifo.sv
// Two-entry first-word fall-through buffer; dout is the head register itself.
module sram_sh_data_rsp_fifo #(
    parameter int W = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         valid,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);

    logic [W-1:0] e0, e1;

    assign valid = (count != 2'd0);
    assign dout  = e0;

    always_ff @(posedge clk) begin
        if (rst) begin
            e0    <= '0;
            e1    <= '0;
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) e0 <= din;
                    else               e1 <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    e0    <= e1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) e0 <= din;
                    else begin
                        e0 <= e1;
                        e1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sram_sh_data_ctrl.sv
// Shared-data SRAM controller: lane-masked request port, zero-init sequencer, 2-deep read buffer.
// Define SRAM_SH_DATA_CTRL_PARITY_EN for per-lane parity and the RSP_PERR output.
module sram_sh_data_ctrl
    import sram_sh_data_pkg::*;
#(
    parameter int ADDR_WIDTH    = 4,
    parameter int DATA_WIDTH    = 128,
    parameter int NB_LANES      = 16,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic                  REQ_WEN,
    input  logic [NB_LANES-1:0]   REQ_BEN,
    input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [DATA_WIDTH-1:0] REQ_WDATA,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic [DATA_WIDTH-1:0] RSP_RDATA,
    output logic                  INIT_DONE
`ifdef SRAM_SH_DATA_CTRL_PARITY_EN
    ,
    output logic [NB_LANES-1:0]   RSP_PERR
`endif
);

    localparam int LANE_W = lane_w(DATA_WIDTH, NB_LANES);
    localparam int DEPTH  = 2**ADDR_WIDTH;
    localparam int CUT_W  = DATA_WIDTH + NB_LANES*PARITY_W;

    fsm_e                  state, state_nxt;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  inflight;
    logic [1:0]            fifo_count;
    logic                  req_acc, rsp_pop;

    logic                  cen, rdwen;
    logic [ADDR_WIDTH-1:0] a;
    logic [CUT_W-1:0]      d, bw, q, wdata_cut, bw_cut;
    logic [DATA_WIDTH-1:0] lane_bw;
    logic [CUT_W-1:0]      fifo_din, fifo_dout;

    assign rsp_pop   = RSP_VALID && RSP_READY;
    assign req_acc   = REQ_VALID && REQ_READY;
    assign INIT_DONE = (state == RUN);
    // Occupancy counts the entry leaving this cycle so reads can stream at one per cycle.
    assign REQ_READY = (state == RUN) &&
                       ((32'(fifo_count) + 32'(inflight) - 32'(rsp_pop)) < 32'd2);

    for (genvar l = 0; l < NB_LANES; l++) begin : g_lane
        assign lane_bw[l*LANE_W +: LANE_W] = {LANE_W{~REQ_BEN[l]}};
    end

`ifdef SRAM_SH_DATA_CTRL_PARITY_EN
    logic [NB_LANES-1:0] par_w, perr;
    for (genvar l = 0; l < NB_LANES; l++) begin : g_par
        assign par_w[l] = ^REQ_WDATA[l*LANE_W +: LANE_W];
        assign perr[l]  = ^{q[DATA_WIDTH+l], q[l*LANE_W +: LANE_W]};
    end
    assign wdata_cut = {par_w, REQ_WDATA};
    assign bw_cut    = {~REQ_BEN, lane_bw};
    assign fifo_din  = {perr, q[DATA_WIDTH-1:0]};
    assign RSP_PERR  = fifo_dout[CUT_W-1:DATA_WIDTH];
`else
    assign wdata_cut = REQ_WDATA;
    assign bw_cut    = lane_bw;
    assign fifo_din  = q;
`endif
    assign RSP_RDATA = fifo_dout[DATA_WIDTH-1:0];

    always_comb begin
        state_nxt = state;
        cen       = 1'b1;
        rdwen     = 1'b1;
        a         = REQ_ADDR;
        d         = '0;
        bw        = '0;
        case (state)
            INIT: begin
                cen   = 1'b0;
                rdwen = 1'b0;
                a     = cnt;
                bw    = '1;
                if (cnt == ADDR_WIDTH'(DEPTH-1)) state_nxt = RUN;
            end
            RUN: begin
                if (req_acc) begin
                    cen   = 1'b0;
                    rdwen = REQ_WEN;
                    d     = wdata_cut;
                    bw    = bw_cut;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= (INIT_ON_RESET != 0) ? INIT : RUN;
            cnt      <= '0;
            inflight <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= req_acc && REQ_WEN;
            if (state == INIT) cnt <= cnt + 1'b1;
        end
    end

    GENERIC_MEM #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(CUT_W)) u_mem (
        .CLK   (CLK),
        .CEN   (cen),
        .RDWEN (rdwen),
        .A     (a),
        .D     (d),
        .BW    (bw),
        .Q     (q)
    );

    sram_sh_data_rsp_fifo #(.W(CUT_W)) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (inflight),
        .din   (fifo_din),
        .pop   (rsp_pop),
        .valid (RSP_VALID),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_sram_sh_data_ctrl.sv
// Randomised bench for sram_sh_data_ctrl against an array/queue memory model.
module tb_sram_sh_data_ctrl;

    localparam int AW = 4;
    localparam int DW = 128;
    localparam int NL = 16;
    localparam int LW = DW / NL;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          REQ_VALID = 1'b0;
    logic          REQ_READY;
    logic          REQ_WEN = 1'b1;
    logic [NL-1:0] REQ_BEN = '1;
    logic [AW-1:0] REQ_ADDR = '0;
    logic [DW-1:0] REQ_WDATA = '0;
    logic          RSP_VALID;
    logic          RSP_READY = 1'b1;
    logic [DW-1:0] RSP_RDATA;
    logic          INIT_DONE;
`ifdef SRAM_SH_DATA_CTRL_PARITY_EN
    logic [NL-1:0] RSP_PERR;
`endif

    sram_sh_data_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NB_LANES(NL), .INIT_ON_RESET(1)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ_VALID (REQ_VALID),
        .REQ_READY (REQ_READY),
        .REQ_WEN   (REQ_WEN),
        .REQ_BEN   (REQ_BEN),
        .REQ_ADDR  (REQ_ADDR),
        .REQ_WDATA (REQ_WDATA),
        .RSP_VALID (RSP_VALID),
        .RSP_READY (RSP_READY),
        .RSP_RDATA (RSP_RDATA),
        .INIT_DONE (INIT_DONE)
`ifdef SRAM_SH_DATA_CTRL_PARITY_EN
        ,
        .RSP_PERR  (RSP_PERR)
`endif
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    always @(posedge CLK) cyc++;

    logic [DW-1:0] mdl [2**AW];
    logic [DW-1:0] exp_q [$];
    bit            mon_en = 1'b0;
    bit            last_acc = 1'b0;
    bit            stall_prev = 1'b0;
    logic [DW-1:0] held;

    task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Scoreboard: apply accepted requests to the model, match responses in order.
    always @(negedge CLK) begin
        if (mon_en) begin
            if (stall_prev) begin
                chk("hold_valid", DW'(RSP_VALID), DW'(1));
                chk("hold_data", RSP_RDATA, held);
            end
            if (REQ_VALID && REQ_READY) begin
                if (!REQ_WEN) begin
                    for (int l = 0; l < NL; l++)
                        if (!REQ_BEN[l]) mdl[REQ_ADDR][l*LW +: LW] = REQ_WDATA[l*LW +: LW];
                end else begin
                    exp_q.push_back(mdl[REQ_ADDR]);
                end
            end
            if (RSP_VALID && RSP_READY) begin
                chk("rsp_expected", DW'(exp_q.size() != 0), DW'(1));
                if (exp_q.size() != 0) chk("rsp_data", RSP_RDATA, exp_q.pop_front());
            end
            stall_prev = RSP_VALID && !RSP_READY;
            held       = RSP_RDATA;
        end
        last_acc = REQ_VALID && REQ_READY;
    end

    task automatic do_reset();
        int n;
        mon_en    = 1'b0;
        RST       = 1'b1;
        REQ_VALID = 1'b0;
        tick();
        chk("rst_req_ready", DW'(REQ_READY), DW'(0));
        chk("rst_rsp_valid", DW'(RSP_VALID), DW'(0));
        chk("rst_rsp_rdata", RSP_RDATA, DW'(0));
        chk("rst_init_done", DW'(INIT_DONE), DW'(0));
        tick();
        RST = 1'b0;
        exp_q.delete();
        stall_prev = 1'b0;
        for (int i = 0; i < 2**AW; i++) mdl[i] = '0;
        n = 0;
        while (!INIT_DONE && n < 40) begin
            if (n == 8) chk("init_req_ready", DW'(REQ_READY), DW'(0));
            tick();
            n++;
        end
        chk("init_cycles", DW'(n), DW'(16));
        RSP_READY = 1'b1;
        mon_en    = 1'b1;
    endtask

    task automatic issue(input logic wen, input logic [NL-1:0] ben, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd);
        int n = 0;
        REQ_VALID = 1'b1;
        REQ_WEN   = wen;
        REQ_BEN   = ben;
        REQ_ADDR  = addr;
        REQ_WDATA = wd;
        while (!REQ_READY && n < 50) begin
            tick();
            n++;
        end
        if (!REQ_READY) chk("req_accept_timeout", DW'(REQ_READY), DW'(1));
        tick();
        REQ_VALID = 1'b0;
    endtask

    // Read with an idle pipeline and RSP_READY high: nothing at t+1, data at t+2.
    task automatic read_chk(input logic [AW-1:0] addr, input logic [DW-1:0] exp);
        issue(1'b1, '1, addr, '0);
        chk("lat_t1_valid", DW'(RSP_VALID), DW'(0));
        tick();
        chk("lat_t2_valid", DW'(RSP_VALID), DW'(1));
        chk("lat_t2_data", RSP_RDATA, exp);
    endtask

    task automatic drain();
        int n = 0;
        REQ_VALID = 1'b0;
        RSP_READY = 1'b1;
        while ((exp_q.size() != 0 || RSP_VALID) && n < 50) begin
            tick();
            n++;
        end
        chk("drain_empty", DW'(exp_q.size()), DW'(0));
    endtask

    initial begin
        int t0;
        do_reset();

        for (int i = 0; i < 2**AW; i++) issue(1'b1, '1, AW'(i), '0);
        drain();

        issue(1'b0, '0, 4'd3, 128'h0123456789ABCDEF0123456789ABCDEF);
        read_chk(4'd3, 128'h0123456789ABCDEF0123456789ABCDEF);
        tick();

        issue(1'b0, 16'hFFFE, 4'd5, {16{8'hAA}});
        read_chk(4'd5, 128'hAA);
`ifdef SRAM_SH_DATA_CTRL_PARITY_EN
        chk("perr_clean", DW'(RSP_PERR), DW'(0));
`endif
        tick();

        t0 = cyc;
        for (int i = 0; i < 8; i++) issue(1'b1, '1, AW'(i), '0);
        chk("b2b_cycles", DW'(cyc - t0), DW'(8));
        drain();

        RSP_READY = 1'b0;
        issue(1'b1, '1, 4'd3, '0);
        issue(1'b1, '1, 4'd5, '0);
        REQ_VALID = 1'b1;
        REQ_ADDR  = 4'd7;
        for (int i = 0; i < 4; i++) begin
            chk("bp_req_ready", DW'(REQ_READY), DW'(0));
            chk("bp_head", RSP_RDATA, 128'h0123456789ABCDEF0123456789ABCDEF);
            tick();
        end
        RSP_READY = 1'b1;
        issue(1'b1, '1, 4'd7, '0);
        issue(1'b1, '1, 4'd8, '0);
        drain();

`ifdef SRAM_SH_DATA_CTRL_PARITY_EN
        issue(1'b0, '0, 4'd9, rnd128());
        dut.u_mem.mem[9][DW+2] = ~dut.u_mem.mem[9][DW+2];
        issue(1'b1, '1, 4'd9, '0);
        tick();
        chk("perr_lane2", DW'(RSP_PERR), DW'(16'h0004));
        drain();
`endif

        for (int c = 0; c < 600; c++) begin
            if (!REQ_VALID || last_acc) begin
                if ($urandom_range(0, 3) == 0) REQ_VALID = 1'b0;
                else begin
                    REQ_VALID = 1'b1;
                    REQ_WEN   = 1'($urandom_range(0, 1));
                    REQ_ADDR  = AW'($urandom_range(0, 15));
                    REQ_WDATA = rnd128();
                    case ($urandom_range(0, 3))
                        0:       REQ_BEN = '0;
                        1:       REQ_BEN = '1;
                        default: REQ_BEN = NL'($urandom);
                    endcase
                end
            end
            RSP_READY = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        RSP_READY = 1'b0;
        issue(1'b1, '1, 4'd3, '0);
        issue(1'b1, '1, 4'd4, '0);
        do_reset();
        for (int i = 0; i < 2**AW; i++) issue(1'b1, '1, AW'(i), '0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
